// File: rtl/divisor16x8_pkg.sv
// Shared constants for the 16/8 restoring divider: operand widths and FSM state encoding.
package divisor16x8_pkg;

    localparam int N_W   = 16;
    localparam int D_W   = 8;
    localparam int Q_W   = 16;
    localparam int R_W   = 8;
    localparam int P_W   = 9;
    localparam int CNT_W = 4;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ITER = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/divisor16x8_if.sv
// Start/done request bus of the divider; master issues operands, slave returns results.
interface divisor16x8_if;
    import divisor16x8_pkg::*;

    logic           start;
    logic [N_W-1:0] N;
    logic [D_W-1:0] D;
    logic           busy;
    logic           done;
    logic           dz;
    logic [Q_W-1:0] Q;
    logic [R_W-1:0] R;

    modport master (output start, N, D, input busy, done, dz, Q, R);
    modport slave  (input start, N, D, output busy, done, dz, Q, R);

endinterface

// File: rtl/divisor16x8_fd.sv
// Divider datapath: dividend shifter Nr, divisor Dr, partial remainder P, quotient Qr, counter.
module divisor16x8_fd
    import divisor16x8_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           iter,
    input  logic           d_zero,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    output logic [Q_W-1:0] q,
    output logic [R_W-1:0] r,
    output logic           dz,
    output logic           last
);

    logic [N_W-1:0]   nr_q, nr_d;
    logic [D_W-1:0]   dr_q;
    logic [P_W-1:0]   p_q, p_d, t, diff;
    logic [Q_W-1:0]   qr_q, qr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_d;
    logic             no_borrow;
    logic             step_en;
    logic             unused_p_msb;

    assign step_en = load | iter;
    assign t       = {p_q[7:0], nr_q[N_W-1]};

    somasub #(.W(P_W)) u_somasub (
        .a    (t),
        .b    ({1'b0, dr_q}),
        .sub  (1'b1),
        .y    (diff),
        .cout (no_borrow)
    );

    always_comb begin
        nr_d  = {nr_q[N_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        p_d   = no_borrow ? diff : t;
        qr_d  = {qr_q[Q_W-2:0], no_borrow};
        dz_d  = 1'b0;
        if (load) begin
            nr_d  = n;
            cnt_d = '0;
            // A zero divisor short-circuits straight to the saturated result.
            if (d_zero) begin
                p_d  = {1'b0, n[7:0]};
                qr_d = '1;
                dz_d = 1'b1;
            end else begin
                p_d  = '0;
                qr_d = '0;
            end
        end
    end

    registrador #(.W(N_W))   u_nr  (.clk(clk), .rst(rst), .en(step_en), .d(nr_d),  .q(nr_q));
    registrador #(.W(D_W))   u_dr  (.clk(clk), .rst(rst), .en(load),    .d(d),     .q(dr_q));
    registrador #(.W(P_W))   u_p   (.clk(clk), .rst(rst), .en(step_en), .d(p_d),   .q(p_q));
    registrador #(.W(Q_W))   u_qr  (.clk(clk), .rst(rst), .en(step_en), .d(qr_d),  .q(qr_q));
    registrador #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .en(step_en), .d(cnt_d), .q(cnt_q));
    registrador #(.W(1))     u_dz  (.clk(clk), .rst(rst), .en(load),    .d(dz_d),  .q(dz));

    // P < Dr keeps the top bit of P at zero; it exists only as headroom for T.
    assign unused_p_msb = p_q[P_W-1];

    assign q    = qr_q;
    assign r    = p_q[R_W-1:0];
    assign last = (cnt_q == 4'd15);

endmodule

// File: rtl/divisor16x8_uc.sv
// Divider control FSM: IDLE -> ITER x16 -> DONE, or IDLE -> DONE on a zero divisor.
module divisor16x8_uc
    import divisor16x8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic d_zero,
    input  logic last,
    output logic load,
    output logic iter,
    output logic busy,
    output logic done
);

    logic [1:0] state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path through the block infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = d_zero ? DONE : ITER;
            ITER:    if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load = (state_q == IDLE) && start;
    assign iter = (state_q == ITER);
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: rtl/registrador.sv
// Generic load-enabled register with asynchronous active-low clear.
module registrador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: state is written with <= so every register samples its inputs before any of them update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/somasub.sv
// Shared W-bit add/sub unit; with sub=1 computes a-b and cout=1 means no borrow.
module somasub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         cout
);

    logic [W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
    assign y    = sum[W-1:0];
    assign cout = sum[W];

endmodule

// File: rtl/divisor16x8.sv
// 16-bit by 8-bit sequential restoring divider, one quotient bit per clock.
module divisor16x8
    import divisor16x8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    divisor16x8_if.slave  bus
);

    logic load, iter, last, d_zero;

    assign d_zero = (bus.D == '0);

    divisor16x8_uc u_uc (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.start),
        .d_zero (d_zero),
        .last   (last),
        .load   (load),
        .iter   (iter),
        .busy   (bus.busy),
        .done   (bus.done)
    );

    divisor16x8_fd u_fd (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .iter   (iter),
        .d_zero (d_zero),
        .n      (bus.N),
        .d      (bus.D),
        .q      (bus.Q),
        .r      (bus.R),
        .dz     (bus.dz),
        .last   (last)
    );

endmodule

// File: tb/tb_divisor16x8.sv
// Directed and random-operand bench for divisor16x8 with hand-computed expectations.
module tb_divisor16x8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    divisor16x8_if bus ();

    divisor16x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wait up to 40 cycles for done; returns the cycle count after the start edge, 99 on timeout.
    task automatic wait_done(input int first, output int lat);
        lat = 99;
        for (int k = first; k <= 40; k++) begin
            if (k > first) @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] n, input logic [7:0] d,
                           input logic [15:0] eq, input logic [7:0] er, input logic edz,
                           input int elat);
        int lat;
        @(negedge clk);
        bus.N     = n;
        bus.D     = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(1, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"},   {16'd0, bus.Q}, {16'd0, eq});
        check({tag, "_r"},   {24'd0, bus.R}, {24'd0, er});
        check({tag, "_dz"},  {31'd0, bus.dz}, {31'd0, edz});
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] rn;
        logic [7:0]  rd;

        bus.start = 1'b0;
        bus.N     = '0;
        bus.D     = '0;
        #12;
        check("rst_outs", {bus.busy, bus.done, bus.dz, bus.Q, bus.R}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("d1000_7",    16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17);
        run_div("d65535_255", 16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17);
        run_div("d65535_1",   16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17);
        run_div("d5_9",       16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 17);
        run_div("d0_3",       16'd0,     8'd3,   16'd0,     8'd0,   1'b0, 17);
        run_div("dz100",      16'd100,   8'd0,   16'hFFFF,  8'h64,  1'b1, 1);
        run_div("after_dz",   16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17);

        // Start pulses mid-operation and during DONE must not disturb the result.
        @(negedge clk);
        bus.N     = 16'd1000;
        bus.D     = 8'd7;
        bus.start = 1'b1;
        lat       = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            bus.start = (k == 5 || k == 16);
            if (k == 5 || k == 16) begin
                bus.N = 16'd12345;
                bus.D = 8'd3;
                check($sformatf("ign_busy%0d", k), {31'd0, bus.busy}, 32'd1);
            end
        end
        bus.start = 1'b0;
        check("ign_lat", lat, 17);
        check("ign_q", {16'd0, bus.Q}, 32'd142);
        check("ign_r", {24'd0, bus.R}, 32'd6);
        @(negedge clk);
        check("ign_idle", {30'd0, bus.done, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of iteration 8.
        @(negedge clk);
        bus.N     = 16'd65535;
        bus.D     = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_outs", {bus.busy, bus.done, bus.dz, bus.Q, bus.R}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("post_rst", 16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 17);

        for (int i = 0; i < 300; i++) begin
            rn = 16'($urandom);
            rd = 8'($urandom_range(1, 255));
            @(negedge clk);
            bus.N     = rn;
            bus.D     = rd;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            wait_done(1, lat);
            check($sformatf("rnd%0d_lat", i), lat, 17);
            check($sformatf("rnd%0d_q", i), {16'd0, bus.Q}, {16'd0, rn / {8'd0, rd}});
            check($sformatf("rnd%0d_r", i), {24'd0, bus.R}, {16'd0, rn % {8'd0, rd}});
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
